// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and data width.
// Used by uart_tx today and intended for the matching uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Clock-per-bit counter. Counts 0..CLKS_PER_BIT-1 and wraps; bit_end marks the
// last cycle of a serial bit. clear holds the counter at 0 so that the first
// bit of a frame is a full CLKS_PER_BIT cycles long.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit timer, held at zero while cleared, wraps on each bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first. A one-cycle tx_start in IDLE
// captures tx_data and sends start, eight data bits and stop, each
// CLKS_PER_BIT clocks long. tx_done pulses for one cycle as the frame ends.
// Handshake: tx_start is a request that is only honoured in IDLE; there is no
// ready output, so requests arriving while a frame is in flight are dropped.
// The IDLE cycle carrying tx_done already accepts a new request.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx,
  output logic                      tx_done
);

  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic                      bit_end;
  logic                      cnt_clear;

  // The bit timer only runs while a frame is being sent.
  assign cnt_clear = (state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .bit_end (bit_end)
  );

  // Frame sequencer with shift register; tx and tx_done are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_idx <= '0;
          if (tx_start) begin
            shreg <= tx_data;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // Present the next bit from the unshifted register, then shift.
              shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Two instances share clock and reset: one with
// CLKS_PER_BIT=4 for the directed scenarios and one with the default 868.
// Every clock cycle the expected {tx_done, tx} pair is taken from a queue
// that is filled when a frame is requested.
module tb_uart_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 868;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0;
  logic [7:0] data_a  = 8'h00;
  logic       tx_a;
  logic       done_a;

  logic       start_b = 1'b0;
  logic [7:0] data_b  = 8'h00;
  logic       tx_b;
  logic       done_b;

  uart_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .tx_start (start_a),
    .tx_data  (data_a),
    .tx       (tx_a),
    .tx_done  (done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .tx_start (start_b),
    .tx_data  (data_b),
    .tx       (tx_b),
    .tx_done  (done_b)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];  // {tx_done, tx} per cycle
  int vectors  = 0;
  int failures = 0;
  int cyc_tag  = 0;

  // Expected line for one 8N1 frame plus the done cycle.
  task automatic push_frame(input logic [7:0] data, input int cpb);
    logic bitv;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      bitv = 1'b0;
      else if (b == 9) bitv = 1'b1;
      else             bitv = data[b-1];
      for (int c = 0; c < cpb; c++) exp_q.push_back({1'b0, bitv});
    end
    exp_q.push_back(2'b11);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b01);
  endtask

  // Compare n cycles on the falling edge; which selects the DUT instance.
  task automatic check_cycles(input int n, input int which, input string tag);
    logic [1:0] obs;
    logic [1:0] expv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = (which == 0) ? {done_a, tx_a} : {done_b, tx_b};
      vectors++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL %s_qempty cycle %0d: got %b with no expected entry", tag, i, obs);
      end
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
          failures++;
          $error("FAIL %s cycle %0d: got {done,tx}=%b expected %b", tag, i, obs, expv);
        end
      end
      cyc_tag++;
    end
  endtask

  // From a falling edge: request a frame on instance A and track it.
  task automatic send_a(input logic [7:0] data, input string tag);
    start_a = 1'b1;
    data_a  = data;
    push_frame(data, CPB_A);
    check_cycles(1, 0, tag);
    start_a = 1'b0;
    data_a  = ~data;  // must not disturb the frame in flight
    check_cycles(10 * CPB_A, 0, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held for two edges; outputs checked during and after.
    @(negedge clk);
    push_idle(2);
    check_cycles(2, 0, "reset");
    rst = 1'b0;
    push_idle(20);
    check_cycles(20, 0, "idle");

    // Single frame 0xA5.
    send_a(8'hA5, "frame_a5");
    push_idle(3);
    check_cycles(3, 0, "post_a5");

    // Mid-frame request with 0xFF must be ignored.
    start_a = 1'b1;
    data_a  = 8'hA5;
    push_frame(8'hA5, CPB_A);
    check_cycles(1, 0, "ign_accept");
    start_a = 1'b0;
    check_cycles(10, 0, "ign_pre");
    start_a = 1'b1;
    data_a  = 8'hFF;
    check_cycles(1, 0, "ign_pulse");
    start_a = 1'b0;
    check_cycles(29, 0, "ign_rest");
    push_idle(5);
    check_cycles(5, 0, "ign_idle");

    // tx_start held: 0x00 then 0x81 back-to-back, 41-cycle period.
    start_a = 1'b1;
    data_a  = 8'h00;
    push_frame(8'h00, CPB_A);
    push_frame(8'h81, CPB_A);
    check_cycles(1, 0, "b2b_first");
    data_a = 8'h81;
    check_cycles(40, 0, "b2b_first");
    check_cycles(6, 0, "b2b_second");
    start_a = 1'b0;
    check_cycles(35, 0, "b2b_second");
    push_idle(4);
    check_cycles(4, 0, "b2b_idle");

    // Reset during data bit 3 aborts the frame without tx_done.
    start_a = 1'b1;
    data_a  = 8'hC6;
    push_frame(8'hC6, CPB_A);
    check_cycles(1, 0, "abort_frame");
    start_a = 1'b0;
    check_cycles(4 + 3 * CPB_A + 1, 0, "abort_frame");
    rst = 1'b1;
    exp_q.delete();
    push_idle(1);
    check_cycles(1, 0, "abort_rst");
    rst = 1'b0;
    push_idle(12);
    check_cycles(12, 0, "abort_idle");
    send_a(8'h3C, "frame_3c");
    push_idle(2);
    check_cycles(2, 0, "post_3c");

    // Default rate: 0x55 with 868 clocks per bit, done at cycle 8680.
    start_b = 1'b1;
    data_b  = 8'h55;
    push_frame(8'h55, CPB_B);
    check_cycles(1, 1, "slow_55");
    start_b = 1'b0;
    data_b  = 8'h00;
    check_cycles(10 * CPB_B, 1, "slow_55");
    push_idle(3);
    check_cycles(3, 1, "slow_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
